// File: rtl/vj_seq_pkg.sv
// Shared types and default cascade configuration for the Viola-Jones stage sequencer.
// NUM_STAGE / NUM_FEATURE macros may be predefined by the weight header; otherwise the defaults below apply.
`ifndef NUM_STAGE
`define NUM_STAGE 2
`endif
`ifndef NUM_FEATURE
`define NUM_FEATURE 4096
`endif

package vj_seq_pkg;

    localparam int ADDR_W        = 12;
    localparam int ACC_W         = 32;
    localparam int STG_W         = 5;
    localparam int NUM_STAGE_DEF = `NUM_STAGE;
    localparam int NUM_FEATURE   = `NUM_FEATURE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DECIDE,
        S_DONE
    } state_t;

    // Entry 0 is the first stage evaluated.
    localparam logic [NUM_STAGE_DEF-1:0][ADDR_W-1:0] STAGE_LEN    = {12'd2, 12'd3};
    localparam logic [NUM_STAGE_DEF-1:0][ACC_W-1:0]  STAGE_THRESH = {-32'sd5, 32'sd10};

endpackage

// File: rtl/vj_stage_acc.sv
// Per-stage accumulator: wrap-around signed sum of returned contributions, received count, threshold compare.
// Sum/count update one cycle after take; all_rcvd_next looks ahead so the FSM can leave DRAIN on the last result.
module vj_stage_acc
    import vj_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              take,
    input  logic [ACC_W-1:0]  val,
    input  logic [ADDR_W-1:0] len,
    input  logic [ACC_W-1:0]  thresh,
    output logic [ADDR_W-1:0] rcv_cnt,
    output logic              all_rcvd_next,
    output logic              pass
);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0] rcv_q, rcv_d;

    always_comb begin
        acc_d = acc_q;
        rcv_d = rcv_q;
        if (clear) begin
            acc_d = '0;
            rcv_d = '0;
        end else if (take) begin
            acc_d = acc_q + val;
            rcv_d = rcv_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            rcv_q <= '0;
        end else begin
            acc_q <= acc_d;
            rcv_q <= rcv_d;
        end
    end

    assign rcv_cnt       = rcv_q;
    assign all_rcvd_next = ((rcv_q + ADDR_W'(take)) == len);
    assign pass          = ($signed(acc_q) >= $signed(thresh));

endmodule

// File: rtl/vj_cascade_sequencer.sv
// Walks the cascade: issues each stage's feature addresses, sums returned contributions, decides pass/fail.
// First rom_en 1 cycle after start; DECIDE 1 cycle after a stage's last result; results may arrive at any latency >= 1.
module vj_cascade_sequencer
    import vj_seq_pkg::*;
#(
    parameter int                                    NUM_STAGE    = vj_seq_pkg::NUM_STAGE_DEF,
    parameter logic [NUM_STAGE-1:0][ADDR_W-1:0]      STAGE_LEN    = vj_seq_pkg::STAGE_LEN,
    parameter logic [NUM_STAGE-1:0][ACC_W-1:0]       STAGE_THRESH = vj_seq_pkg::STAGE_THRESH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    output logic              feat_valid,
    output logic [ADDR_W-1:0] feat_idx,
    input  logic              result_valid,
    input  logic [ACC_W-1:0]  result_val,
    output logic              done,
    output logic              is_face,
    output logic [STG_W-1:0]  fail_stage,
    output logic              proto_err
);

    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGE - 1);

    state_t            state_q, state_d;
    logic [STG_W-1:0]  stage_q, stage_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] iss_q, iss_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [ADDR_W-1:0] feat_idx_q, feat_idx_d;
    logic              feat_valid_q, feat_valid_d;
    logic              is_face_q, is_face_d;
    logic [STG_W-1:0]  fail_stage_q, fail_stage_d;
    logic              proto_err_q, proto_err_d;

    logic [ADDR_W-1:0] cur_len;
    logic [ACC_W-1:0]  cur_th;
    logic [ADDR_W-1:0] rcv_cnt;
    logic              issue, take, acc_clear, all_rcvd_next, pass;

    always_comb begin
        cur_len = '0;
        cur_th  = '0;
        for (int i = 0; i < NUM_STAGE; i++) begin
            if (stage_q == STG_W'(i)) begin
                cur_len = STAGE_LEN[i];
                cur_th  = STAGE_THRESH[i];
            end
        end
    end

    assign issue = (state_q == S_ISSUE) && (iss_q != cur_len);
    // A result is only legal while at least one issued feature is still outstanding.
    assign take  = result_valid && ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && (rcv_cnt != iss_q);

    vj_stage_acc u_acc (
        .clk           (clk),
        .reset         (reset),
        .clear         (acc_clear),
        .take          (take),
        .val           (result_val),
        .len           (cur_len),
        .thresh        (cur_th),
        .rcv_cnt       (rcv_cnt),
        .all_rcvd_next (all_rcvd_next),
        .pass          (pass)
    );

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        ptr_d        = issue ? ptr_q + ADDR_W'(1) : ptr_q;
        iss_d        = issue ? iss_q + ADDR_W'(1) : iss_q;
        last_addr_d  = issue ? ptr_q : last_addr_q;
        feat_valid_d = issue;
        feat_idx_d   = rom_addr;
        is_face_d    = is_face_q;
        fail_stage_d = fail_stage_q;
        proto_err_d  = proto_err_q | (result_valid & ~take);
        acc_clear    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ISSUE;
                    stage_d   = '0;
                    ptr_d     = '0;
                    iss_d     = '0;
                    acc_clear = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!issue || ((iss_q + ADDR_W'(1)) == cur_len)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (all_rcvd_next) begin
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                iss_d = '0;
                if (pass && (stage_q != LAST_STG)) begin
                    state_d   = S_ISSUE;
                    stage_d   = stage_q + STG_W'(1);
                    acc_clear = 1'b1;
                end else begin
                    state_d      = S_DONE;
                    is_face_d    = pass;
                    fail_stage_d = stage_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            stage_q      <= '0;
            ptr_q        <= '0;
            iss_q        <= '0;
            last_addr_q  <= '0;
            feat_idx_q   <= '0;
            feat_valid_q <= 1'b0;
            is_face_q    <= 1'b0;
            fail_stage_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            ptr_q        <= ptr_d;
            iss_q        <= iss_d;
            last_addr_q  <= last_addr_d;
            feat_idx_q   <= feat_idx_d;
            feat_valid_q <= feat_valid_d;
            is_face_q    <= is_face_d;
            fail_stage_q <= fail_stage_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign rom_en     = issue;
    assign rom_addr   = issue ? ptr_q : last_addr_q;
    assign feat_valid = feat_valid_q;
    assign feat_idx   = feat_idx_q;
    assign done       = (state_q == S_DONE);
    assign is_face    = is_face_q;
    assign fail_stage = fail_stage_q;
    assign proto_err  = proto_err_q;

endmodule

// File: doc/vj_cascade_sequencer.md
VJ_CASCADE_SEQUENCER -- requirements
Module: vj_cascade_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGE, default `NUM_STAGE from vj_weights.vh, the number of cascade stages (1..32).
REQ-002 SHALL have parameter STAGE_LEN, default vj_seq_pkg::STAGE_LEN, a per-stage feature count array of NUM_STAGE x 12-bit entries, summing to at most `NUM_FEATURE.
REQ-003 SHALL have parameter STAGE_THRESH, default vj_seq_pkg::STAGE_THRESH, a per-stage signed 32-bit threshold array of NUM_STAGE entries.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  begin evaluating one window; sampled only in IDLE.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 rom_addr  out  12  feature index driven to the weight block memories (addra).
REQ-009 rom_en  out  1  rom_addr is a valid issue this cycle.
REQ-010 feat_valid  out  1  rom_en delayed 1 cycle, aligned with block-memory douta.
REQ-011 feat_idx  out  12  rom_addr delayed 1 cycle.
REQ-012 result_valid  in  1  datapath returns one feature contribution, in issue order, at any latency >= 1.
REQ-013 result_val  in  32  signed feature contribution.
REQ-014 done  out  1  one-cycle pulse when the verdict is final.
REQ-015 is_face  out  1  verdict; valid from done until the next accepted start.
REQ-016 fail_stage  out  5  index of the first failing stage; NUM_STAGE-1 when is_face=1.
REQ-017 proto_err  out  1  sticky; set by result_valid with zero outstanding results.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, DRAIN, DECIDE and DONE.
REQ-019 IDLE transitions to ISSUE on start; the stage, the address and the accumulator clear to 0.
REQ-020 ISSUE asserts rom_en every cycle with consecutive rom_addr; after the last feature of the stage it transitions to DRAIN.
REQ-021 A stage with STAGE_LEN=0 issues nothing, and ISSUE transitions directly to DRAIN.
REQ-022 DRAIN holds until received count equals STAGE_LEN, then transitions to DECIDE; results arriving during ISSUE count toward this.
REQ-023 The accumulator SHALL be a 32-bit two's-complement sum with wrap-around and no saturation; each result_valid adds result_val.
REQ-024 DECIDE defines pass as signed accumulator >= STAGE_THRESH[stage].
REQ-025 On pass with stages remaining, DECIDE transitions to ISSUE with stage+1 and the accumulator cleared; rom_addr continues from the previous stage's end address.
REQ-026 On fail, or on pass of the last stage, DECIDE transitions to DONE.
REQ-027 DONE lasts one cycle with done=1, registers is_face and fail_stage, and then transitions to IDLE.
REQ-028 Latency from start to the first rom_en SHALL be 1 cycle; from the last result of a stage to DECIDE, 1 cycle.
REQ-029 start outside IDLE SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-030 result_valid outside ISSUE or DRAIN, or beyond STAGE_LEN, SHALL be dropped and SHALL set proto_err.
REQ-031 rom_addr SHALL hold its last value when rom_en=0.

Reset
REQ-032 When reset is asserted, the block SHALL be in IDLE at the next edge, regardless of state, with counters and the accumulator at 0.
REQ-033 Reset values: busy, rom_en, feat_valid, done, is_face and proto_err = 0; rom_addr, feat_idx and fail_stage = 0.
REQ-034 After a mid-evaluation reset, late result_valid pulses SHALL set proto_err; the bench clears it with reset.

Structure
REQ-035 Package vj_seq_pkg SHALL hold the state enum, STAGE_LEN, STAGE_THRESH, and width constants (ADDR_W=12, ACC_W=32, STG_W=5).
REQ-036 A sub-module vj_stage_acc (accumulator plus received counter plus compare) SHALL be used; the rest is a single FSM.

Verification
REQ-037 NUM_STAGE=2, LEN={3,2}, TH={10,-5}; results 4,4,4 then -3,-1: addr 0,1,2,3,4; done, is_face=1, fail_stage=1.
REQ-038 Same configuration; results 4,4,1 (sum 9 < 10): no issue at addr 3; done, is_face=0, fail_stage=0.
REQ-039 Results with latency 5 in stage 0: DRAIN holds until the 3rd result; DECIDE occurs 1 cycle later.
REQ-040 LEN={0,1}, TH={0,7}: stage 0 passes with sum 0; result 7 gives is_face=1.
REQ-041 Accumulate 0x7FFFFFFF+1: wraps to 0x80000000 and fails TH=0; start pulsed while busy is ignored.
REQ-042 Reset asserted mid-DRAIN: next cycle busy=0 and rom_en=0; a late result_valid sets proto_err=1.
